// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-requester arbiter onto one registered memory port with in-order read responses.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_port_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] tag_id [RD_LAT+1];
  logic [RD_LAT:0]  tag_rd;
  int               gi;
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gi = -1;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[k]) gi = k;
  end
`else
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] ptr;
  // search starts just after the last granted requester, wrapping
  always_comb begin
    gi = -1;
    for (int k = 1; k <= N_REQ; k++)
      if (gi < 0 && req_valid[(int'(ptr) + k) % N_REQ]) gi = (int'(ptr) + k) % N_REQ;
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= PW'(N_REQ - 1);
    else if (gi >= 0) ptr <= PW'(gi);
`endif
  always_comb begin
    gnt = '0;
    if (gi >= 0) gnt[gi] = 1'b1;
  end
  assign req_ready = rst_n ? gnt : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_rd    <= '0;
      for (int s = 0; s <= RD_LAT; s++) tag_id[s] <= '0;
    end else begin
      mem_we    <= gi >= 0 ? req_we[gi] : 1'b0;
      if (gi >= 0) begin
        mem_addr  <= req_addr[gi*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[gi*DATA_W +: DATA_W];
      end
      tag_id[0] <= gnt;
      tag_rd[0] <= gi >= 0 ? !req_we[gi] : 1'b0;
      for (int s = 1; s <= RD_LAT; s++) begin
        tag_id[s] <= tag_id[s-1];
        tag_rd[s] <= tag_rd[s-1];
      end
    end
  end
  // last stage lines up with mem_rdata for the access issued RD_LAT cycles earlier
  assign rsp_valid = tag_rd[RD_LAT] ? tag_id[RD_LAT] : '0;
  assign rsp_rdata = tag_rd[RD_LAT] ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int N = 3, A = 6, D = 14, L = 2;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [N*A-1:0]   req_addr;
  logic [N*D-1:0]   req_wdata;
  logic [D-1:0]     rsp_rdata, mem_wdata, mem_rdata;
  logic [A-1:0]     mem_addr;
  logic             mem_we;
  mem_port_arbiter #(.N_REQ(N), .ADDR_W(A), .DATA_W(D), .RD_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  typedef struct { int due; int id; logic [D-1:0] data; } rsp_t;
  rsp_t         q[$];
  logic [D-1:0] mem [2**A];
  logic [D-1:0] mdl [2**A];
  logic [D-1:0] pipe [L];
  int checks = 0, failures = 0, cyc = 0, last = N - 1, eg;
  bit armed = 0;
  logic         e_we;
  logic [A-1:0] e_addr;
  logic [D-1:0] e_wd;
  logic [N-1:0] ev;
  logic [D-1:0] ed;
  assign mem_rdata = pipe[L-1];
  function automatic logic [D-1:0] init_val(input int a);
    return a == 5 ? 14'h1ABC : D'((a * 37) ^ 'h2C5);
  endfunction
  function automatic int exp_grant(input logic [N-1:0] v, input int lst);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(lst + k) % N]) return (lst + k) % N;
`endif
    return -1;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  // memory behind the port: write at the edge, read data RD_LAT cycles after the address
  initial begin
    for (int a = 0; a < 2**A; a++) mem[a] = init_val(a);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
      pipe[0] <= mem[mem_addr];
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
  end
  // reference model: grant order, port contents and response queue per accepted transaction
  initial begin
    for (int a = 0; a < 2**A; a++) mdl[a] = init_val(a);
    forever begin
      @(negedge clk);
      eg = rst_n ? exp_grant(req_valid, last) : -1;
      if (armed) begin
        check("ready", 32'(req_ready), eg < 0 ? 32'd0 : 32'(1 << eg));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        ev = '0;
        ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          ev = N'(1 << q[0].id);
          ed = q[0].data;
          void'(q.pop_front());
        end
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("rsp_rdata", 32'(rsp_rdata), 32'(ed));
      end
      if (!rst_n) begin
        armed = 1;
        last = N - 1;
        e_we = 0;
        e_addr = '0;
        e_wd = '0;
        q.delete();
      end else if (armed && eg >= 0) begin
        e_we = req_we[eg];
        e_addr = req_addr[eg*A +: A];
        e_wd = req_wdata[eg*D +: D];
        last = eg;
        if (e_we) mdl[e_addr] = e_wd;
        else q.push_back('{due: cyc + 1 + L, id: eg, data: mdl[e_addr]});
      end else e_we = 0;
      cyc++;
    end
  end
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] w,
                      input logic [N*A-1:0] a, input logic [N*D-1:0] d);
    rst_n = r;
    req_valid = v;
    req_we = w;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, '0, '0, $urandom, {$urandom, $urandom});
  endtask
  initial begin
    step(0, '0, '0, '0, '0);
    step(0, '0, '0, '0, '0);
    step(1, 3'b001, 3'b000, {6'h11, 6'h22, 6'h05}, '0);
    idle(4);
    step(0, '0, '0, '0, '0);
    for (int i = 0; i < 6; i++) step(1, 3'b111, 3'b000, {6'h03, 6'h02, 6'h01}, '0);
    idle(4);
    step(1, 3'b010, 3'b010, {6'h00, 6'h3F, 6'h00}, {14'h0, 14'h2A5A, 14'h0});
    step(1, 3'b100, 3'b000, {6'h3F, 6'h00, 6'h00}, '0);
    idle(5);
    step(1, 3'b001, 3'b000, {6'h0C, 6'h0B, 6'h0A}, '0);
    step(1, 3'b010, 3'b000, {6'h0C, 6'h0B, 6'h0A}, '0);
    step(1, 3'b100, 3'b000, {6'h0C, 6'h0B, 6'h0A}, '0);
    idle(5);
    step(1, 3'b001, 3'b000, {6'h00, 6'h00, 6'h07}, '0);
    step(0, 3'b111, 3'b000, '0, '0);
    idle(6);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) != 0, N'($urandom), N'($urandom), N*A'({$urandom, $urandom}),
           N*D'({$urandom, $urandom}));
    idle(8);
    @(negedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 6: memory address width.
REQ-003 SHALL have parameter DATA_W, default 14: memory data width.
REQ-004 SHALL have parameter RD_LAT, default 2: cycles from mem_addr driven to mem_rdata valid.
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req_valid  input  N_REQ  per-requester request valid.
REQ-009 req_ready  output  N_REQ  per-requester grant; one-hot or zero.
REQ-010 req_we  input  N_REQ  1 = write, 0 = read.
REQ-011 req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-012 req_wdata  input  N_REQ*DATA_W  packed write data, same packing.
REQ-013 rsp_valid  output  N_REQ  one-cycle read-response strobe, at most one bit set.
REQ-014 rsp_rdata  output  DATA_W  shared read data, qualified by rsp_valid.
REQ-015 mem_addr  output  ADDR_W  registered address to the memory port.
REQ-016 mem_we  output  1  registered write enable to the memory port.
REQ-017 mem_wdata  output  DATA_W  registered write data to the memory port.
REQ-018 mem_rdata  input  DATA_W  memory read data.

Function
REQ-019 Grant: at most one requester per cycle; req_ready[i] combinational from req_valid and arbitration state; request accepted when req_valid[i] & req_ready[i].
REQ-020 No valid requester: req_ready = 0, mem_we = 0 next cycle, mem_addr/mem_wdata hold.
REQ-021 Accept in cycle T: mem_addr, mem_we, mem_wdata = that requester's fields in cycle T+1; one access per cycle, back-to-back, no bubbles.
REQ-022 Read accepted in T: rsp_valid[i] = 1 and rsp_rdata = mem_rdata in cycle T+1+RD_LAT; exactly one pulse per read.
REQ-023 Writes produce no response.
REQ-024 Tag pipeline: RD_LAT+1 stages carrying one-hot requester id plus read flag; responses return in acceptance order.
REQ-025 Round-robin (default): pointer = last granted index; search starts at pointer+1 modulo N_REQ, wrapping; pointer updates only on accept.
REQ-026 A requester holding req_valid SHALL be granted within N_REQ cycles.
REQ-027 Request fields sampled only on accept; changing them while not granted is legal.
REQ-028 rsp_rdata SHALL be 0 in cycles where rsp_valid = 0.

Reset
REQ-029 rst_n low at a rising edge: pointer = N_REQ-1 (requester 0 wins first), mem_we = 0, mem_addr = 0, mem_wdata = 0, rsp_valid = 0, rsp_rdata = 0, tag pipeline cleared.
REQ-030 req_ready = 0 while rst_n is low.
REQ-031 Reset mid-operation: in-flight reads discarded, no rsp_valid for them after reset deasserts.

Configuration
REQ-032 Macro MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer logic absent; REQ-026 not required.
REQ-033 Macro MEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-025/REQ-026.

Verification
REQ-034 Reset, then req 0 reads addr 0x05 (memory holds 0x1ABC) in T -> mem_addr = 0x05 in T+1; rsp_valid = 3'b001, rsp_rdata = 0x1ABC in T+3.
REQ-035 All three valid continuously, default build -> grants 0,1,2,0,1,2; fixed-prio build -> grant 0 every cycle.
REQ-036 Req 1 writes 0x2A5A to addr 0x3F in T, req 2 reads 0x3F in T+1 -> rsp_valid = 3'b100, rsp_rdata = 0x2A5A in T+4; no response for the write.
REQ-037 Reads from req 0, 1, 2 accepted in consecutive cycles -> rsp_valid 001, 010, 100 in consecutive cycles, with matching data.
REQ-038 Read accepted, rst_n low for one cycle at T+1 -> no rsp_valid in T+2..T+5; all outputs at reset values in T+2.
